// File: rtl/mmio_register_bank_pkg.sv
// rtl/mmio_register_bank_pkg.sv - shared types and window offsets for mmio_register_bank
package mmio_register_bank_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } mmio_state_t;

  typedef struct packed {
    logic        write;
    logic [31:0] address;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mmio_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        error;
  } mmio_rsp_t;

  localparam logic [31:0] CONTROL_OFFSET = 32'd0;

  function automatic logic [31:0] status_offset(int num_control);
    return 32'(num_control);
  endfunction

  function automatic logic [31:0] change_offset(int num_control, int num_status);
    return 32'(num_control + num_status);
  endfunction

  function automatic logic [31:0] irq_enable_offset(int num_control, int num_status);
    return 32'(num_control + num_status + 1);
  endfunction

  function automatic logic [31:0] strobe_mask(logic [3:0] wstrb);
    return {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
  endfunction

endpackage

// File: rtl/mmio_change_detector.sv
// rtl/mmio_change_detector.sv - status sampling with sticky write-1-to-clear change flags
module mmio_change_detector #(
  parameter int NUM_STATUS = 1
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic [32*NUM_STATUS-1:0] status_i,
  input  logic                    clr_valid_i,
  input  logic [NUM_STATUS-1:0]   clr_mask_i,
  output logic [32*NUM_STATUS-1:0] sample_o,
  output logic [NUM_STATUS-1:0]   flags_o
);

  logic                     prime_q;
  logic [32*NUM_STATUS-1:0] sample_q;
  logic [NUM_STATUS-1:0]    flags_q, flags_d, set;

  // The first cycle after reset only seeds the samples, so a non-zero status
  // at reset release is not mistaken for a change.
  always_comb begin
    set = '0;
    for (int j = 0; j < NUM_STATUS; j++) begin
      set[j] = !prime_q && (status_i[32*j +: 32] != sample_q[32*j +: 32]);
    end
    flags_d = flags_q;
    if (clr_valid_i) flags_d = flags_d & ~clr_mask_i;
    flags_d = flags_d | set;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prime_q  <= 1'b1;
      sample_q <= '0;
      flags_q  <= '0;
    end else begin
      prime_q  <= 1'b0;
      sample_q <= status_i;
      flags_q  <= flags_d;
    end
  end

  assign sample_o = sample_q;
  assign flags_o  = flags_q;

endmodule

// File: rtl/mmio_register_bank.sv
// rtl/mmio_register_bank.sv - control/status register window with valid/ready handshake; option MMIO_CHANGE_IRQ_EN
module mmio_register_bank
  import mmio_register_bank_pkg::*;
#(
  parameter int          NUM_CONTROL   = 6,
  parameter int          NUM_STATUS    = 1,
  parameter logic [31:0] BASE_ADDR     = 32'h20,
  parameter logic [31:0] CONTROL_RESET = 32'h0
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [31:0]              req_address,
  input  logic [31:0]              req_wdata,
  input  logic [3:0]               req_wstrb,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [31:0]              rsp_rdata,
  output logic                     rsp_error,
  input  logic [32*NUM_STATUS-1:0]  status_in,
  output logic [32*NUM_CONTROL-1:0] control_out,
  output logic                     irq
);

  localparam logic [31:0] STATUS_OFF = status_offset(NUM_CONTROL);
  localparam logic [31:0] CHANGE_OFF = change_offset(NUM_CONTROL, NUM_STATUS);

  mmio_req_t   req;
  mmio_rsp_t   rsp_q, rsp_d;
  mmio_state_t state_q, state_d;

  logic [31:0]              ctrl_q [NUM_CONTROL];
  logic [31:0]              ctrl_d [NUM_CONTROL];
  logic [32*NUM_STATUS-1:0] sample;
  logic [NUM_STATUS-1:0]    flags, irq_mask;
  logic [31:0]              offset, byte_mask, wmask;
  logic                     accept, is_ctrl, is_stat, is_change, is_irqen, clr_valid;

  assign req = '{write: req_write, address: req_address, wdata: req_wdata, wstrb: req_wstrb};

  assign req_ready = (state_q == IDLE) || rsp_ready;
  assign accept    = req_valid && req_ready;

  // Unsigned wrap pushes addresses below BASE_ADDR far out of the window.
  assign offset    = req.address - BASE_ADDR;
  assign byte_mask = strobe_mask(req.wstrb);
  assign wmask     = req.wdata & byte_mask;
  assign is_ctrl   = offset < STATUS_OFF;
  assign is_stat   = (offset >= STATUS_OFF) && (offset < CHANGE_OFF);
  assign is_change = offset == CHANGE_OFF;
  assign clr_valid = accept && req.write && is_change;

  mmio_change_detector #(
    .NUM_STATUS (NUM_STATUS)
  ) u_change (
    .clock       (clock),
    .reset_n     (reset_n),
    .status_i    (status_in),
    .clr_valid_i (clr_valid),
    .clr_mask_i  (wmask[NUM_STATUS-1:0]),
    .sample_o    (sample),
    .flags_o     (flags)
  );

`ifdef MMIO_CHANGE_IRQ_EN
  localparam logic [31:0] IRQEN_OFF = irq_enable_offset(NUM_CONTROL, NUM_STATUS);

  logic [NUM_STATUS-1:0] irqen_q, irqen_d;
  logic                  irq_q;

  assign is_irqen = offset == IRQEN_OFF;
  assign irqen_d  = (accept && req.write && is_irqen)
                  ? ((irqen_q & ~byte_mask[NUM_STATUS-1:0]) | wmask[NUM_STATUS-1:0])
                  : irqen_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      irqen_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      irqen_q <= irqen_d;
      irq_q   <= |(flags & irqen_q);
    end
  end

  assign irq      = irq_q;
  assign irq_mask = irqen_q;
`else
  assign is_irqen = 1'b0;
  assign irq      = 1'b0;
  assign irq_mask = '0;
`endif

  always_comb begin
    rsp_d = '0;
    if (is_ctrl || is_stat || is_change || is_irqen) begin
      if (req.write) begin
        rsp_d.error = is_stat;
      end else begin
        for (int i = 0; i < NUM_CONTROL; i++) begin
          if (offset == CONTROL_OFFSET + 32'(i)) rsp_d.rdata = ctrl_q[i];
        end
        for (int j = 0; j < NUM_STATUS; j++) begin
          if (offset == STATUS_OFF + 32'(j)) rsp_d.rdata = sample[32*j +: 32];
        end
        if (is_change) rsp_d.rdata = 32'(flags);
        if (is_irqen)  rsp_d.rdata = 32'(irq_mask);
      end
    end else begin
      rsp_d.error = 1'b1;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CONTROL; i++) begin
      ctrl_d[i] = ctrl_q[i];
      if (accept && req.write && (offset == CONTROL_OFFSET + 32'(i))) begin
        ctrl_d[i] = (ctrl_q[i] & ~byte_mask) | wmask;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = RESP;
    end else if ((state_q == RESP) && rsp_ready) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      rsp_q   <= '0;
      for (int i = 0; i < NUM_CONTROL; i++) ctrl_q[i] <= CONTROL_RESET;
    end else begin
      state_q <= state_d;
      if (accept) rsp_q <= rsp_d;
      for (int i = 0; i < NUM_CONTROL; i++) ctrl_q[i] <= ctrl_d[i];
    end
  end

  for (genvar g = 0; g < NUM_CONTROL; g++) begin : g_ctrl_out
    assign control_out[32*g +: 32] = ctrl_q[g];
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rsp_q.rdata;
  assign rsp_error = rsp_q.error;

endmodule

// File: tb/tb_mmio_register_bank.sv
// tb/tb_mmio_register_bank.sv - self-checking bench for mmio_register_bank against a transaction-level model
module tb_mmio_register_bank;

  localparam int          NC   = 6;
  localparam int          NS   = 1;
  localparam logic [31:0] BASE = 32'h20;

  logic          clock = 1'b0;
  logic          reset_n = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [31:0]   req_address = '0;
  logic [31:0]   req_wdata = '0;
  logic [3:0]    req_wstrb = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [31:0]   rsp_rdata;
  logic          rsp_error;
  logic [31:0]   status_in = '0;
  logic [32*NC-1:0] control_out;
  logic          irq;

  mmio_register_bank dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_address (req_address),
    .req_wdata   (req_wdata),
    .req_wstrb   (req_wstrb),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_error   (rsp_error),
    .status_in   (status_in),
    .control_out (control_out),
    .irq         (irq)
  );

  always #5 clock = ~clock;

  int total = 0;
  int passed = 0;

  // Reference model state
  logic [31:0] ctrl_m [NC];
  logic [31:0] sample_m, flags_m, irqen_m, exp_rdata;
  logic        exp_err, m_busy, prime_m, irq_m;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, got, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NC; i++) ctrl_m[i] = 32'h0;
    sample_m = '0; flags_m = '0; irqen_m = '0; exp_rdata = '0;
    exp_err = 1'b0; m_busy = 1'b0; prime_m = 1'b1; irq_m = 1'b0;
  endtask

  function automatic logic [31:0] lanes(input logic [3:0] s);
    logic [31:0] m;
    m = '0;
    for (int k = 0; k < 4; k++) if (s[k]) m += 32'hFF << (8 * k);
    return m;
  endfunction

  task automatic model_access(input logic w, input logic [31:0] a, input logic [31:0] d,
                              input logic [3:0] s, output logic [31:0] clr);
    logic [31:0] o;
    o = a - BASE;
    clr = '0; exp_rdata = '0; exp_err = 1'b0;
    if (o < NC) begin
      if (w) ctrl_m[o] = (ctrl_m[o] & ~lanes(s)) | (d & lanes(s));
      else   exp_rdata = ctrl_m[o];
    end else if (o < NC + NS) begin
      if (w) exp_err = 1'b1;
      else   exp_rdata = sample_m;
    end else if (o == NC + NS) begin
      if (w) clr = d & lanes(s) & 32'h1;
      else   exp_rdata = flags_m;
`ifdef MMIO_CHANGE_IRQ_EN
    end else if (o == NC + NS + 1) begin
      if (w) irqen_m = ((irqen_m & ~lanes(s)) | (d & lanes(s))) & 32'h1;
      else   exp_rdata = irqen_m;
`endif
    end else begin
      exp_err = 1'b1;
    end
  endtask

  // One clock edge: the model consumes the inputs held across that edge.
  task automatic tick();
    logic        acc, irq_next;
    logic [31:0] clr;
    acc      = reset_n && req_valid && (!m_busy || rsp_ready);
    irq_next = |(flags_m & irqen_m);
    clr      = '0;
    @(posedge clock);
    if (reset_n) begin
      if (acc) begin
        model_access(req_write, req_address, req_wdata, req_wstrb, clr);
        m_busy = 1'b1;
      end else if (rsp_ready) begin
        m_busy = 1'b0;
      end
      flags_m = (flags_m & ~clr) | ((!prime_m && status_in != sample_m) ? 32'h1 : 32'h0);
      sample_m = status_in;
      prime_m  = 1'b0;
      irq_m    = irq_next;
    end
    #1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'(m_busy));
    chk({tag, " req_ready"}, 32'(req_ready), 32'(!m_busy || rsp_ready));
    if (m_busy) begin
      chk({tag, " rdata"}, rsp_rdata, exp_rdata);
      chk({tag, " error"}, 32'(rsp_error), 32'(exp_err));
    end
    for (int i = 0; i < NC; i++)
      chk($sformatf("%s ctrl%0d", tag, i), control_out[32*i +: 32], ctrl_m[i]);
    chk({tag, " irq"}, 32'(irq), 32'(irq_m));
  endtask

  task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    req_valid = 1'b1; req_write = w; req_address = a; req_wdata = d; req_wstrb = s;
  endtask

  task automatic xfer(input string tag, input logic w, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s);
    rsp_ready = 1'b1;
    drive(w, a, d, s);
    tick();
    check_all(tag);
    req_valid = 1'b0;
  endtask

  task automatic settle();
    req_valid = 1'b0; rsp_ready = 1'b1;
    tick();
    check_all("settle");
  endtask

  initial begin
    model_reset();
    #2 reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset rsp_valid", 32'(rsp_valid), 32'h0);
    chk("reset rdata", rsp_rdata, 32'h0);
    chk("reset error", 32'(rsp_error), 32'h0);
    chk("reset ctrl", control_out[31:0] | control_out[191:160], 32'h0);
    chk("reset irq", 32'(irq), 32'h0);
    chk("reset req_ready", 32'(req_ready), 32'h1);

    // Non-zero status at release must not raise a flag on the prime edge.
    status_in = 32'h3;
    reset_n = 1'b1;
    tick();
    check_all("prime");
    xfer("rd chg after prime", 1'b0, 32'h27, 32'h0, 4'h0);
    chk("prime flag", rsp_rdata, 32'h0);

    xfer("wr 0x20", 1'b1, 32'h20, 32'hDEADBEEF, 4'hF);
    chk("wr 0x20 ctrl0", control_out[31:0], 32'hDEADBEEF);
    xfer("rd 0x20", 1'b0, 32'h20, 32'h0, 4'h0);
    chk("rd 0x20 data", rsp_rdata, 32'hDEADBEEF);
    chk("rd 0x20 err", 32'(rsp_error), 32'h0);

    xfer("wr 0x21", 1'b1, 32'h21, 32'hAABBCCDD, 4'b0101);
    xfer("rd 0x21", 1'b0, 32'h21, 32'h0, 4'h0);
    chk("rd 0x21 data", rsp_rdata, 32'h00BB00DD);
    xfer("wr strb0", 1'b1, 32'h21, 32'hFFFFFFFF, 4'h0);
    chk("strb0 err", 32'(rsp_error), 32'h0);
    chk("strb0 ctrl1", control_out[63:32], 32'h00BB00DD);

    status_in = 32'h5;
    settle();
    xfer("rd 0x26", 1'b0, 32'h26, 32'h0, 4'h0);
    chk("rd 0x26 data", rsp_rdata, 32'h5);
    xfer("rd 0x27", 1'b0, 32'h27, 32'h0, 4'h0);
    chk("rd 0x27 data", rsp_rdata, 32'h1);
    xfer("w1c", 1'b1, 32'h27, 32'h1, 4'hF);
    xfer("rd 0x27 clr", 1'b0, 32'h27, 32'h0, 4'h0);
    chk("w1c flag", rsp_rdata, 32'h0);
    status_in = 32'h7;
    xfer("w1c+set", 1'b1, 32'h27, 32'h1, 4'hF);
    xfer("rd 0x27 set", 1'b0, 32'h27, 32'h0, 4'h0);
    chk("set wins", rsp_rdata, 32'h1);

    xfer("wr 0x26", 1'b1, 32'h26, 32'h12345678, 4'hF);
    chk("wr status err", 32'(rsp_error), 32'h1);
    xfer("rd 0x26 again", 1'b0, 32'h26, 32'h0, 4'h0);
    chk("sample kept", rsp_rdata, 32'h7);
    xfer("rd 0x29", 1'b0, 32'h29, 32'h0, 4'h0);
    chk("0x29 err", 32'(rsp_error), 32'h1);
    chk("0x29 data", rsp_rdata, 32'h0);
    xfer("rd 0x1F", 1'b0, 32'h1F, 32'h0, 4'h0);
    chk("0x1F err", 32'(rsp_error), 32'h1);
    chk("0x1F data", rsp_rdata, 32'h0);

    settle();
    rsp_ready = 1'b0;
    drive(1'b0, 32'h20, 32'h0, 4'h0);
    tick();
    check_all("stall first");
    drive(1'b0, 32'h21, 32'h0, 4'h0);
    for (int c = 0; c < 3; c++) begin
      tick();
      check_all("stall hold");
      chk("stall req_ready", 32'(req_ready), 32'h0);
      chk("stall data", rsp_rdata, 32'hDEADBEEF);
    end
    rsp_ready = 1'b1;
    #1;
    chk("release req_ready", 32'(req_ready), 32'h1);
    tick();
    check_all("stall release");
    chk("release data", rsp_rdata, 32'h00BB00DD);
    req_valid = 1'b0;
    settle();

`ifdef MMIO_CHANGE_IRQ_EN
    xfer("clr all", 1'b1, 32'h27, 32'hFFFFFFFF, 4'hF);
    xfer("irqen", 1'b1, 32'h28, 32'h1, 4'hF);
    status_in = status_in ^ 32'h1;
    tick();
    check_all("irq flag edge");
    chk("irq not yet", 32'(irq), 32'h0);
    tick();
    check_all("irq edge");
    chk("irq set", 32'(irq), 32'h1);
    xfer("irq w1c", 1'b1, 32'h27, 32'h1, 4'hF);
    tick();
    check_all("irq after w1c");
    chk("irq cleared", 32'(irq), 32'h0);
`else
    xfer("rd 0x28", 1'b0, 32'h28, 32'h0, 4'h0);
    chk("0x28 err", 32'(rsp_error), 32'h1);
`endif

    for (int n = 0; n < 300; n++) begin
      req_valid   = ($urandom_range(0, 3) != 0);
      req_write   = $urandom_range(0, 1) == 1;
      req_address = 32'h1E + $urandom_range(0, 12);
      req_wdata   = $urandom;
      req_wstrb   = 4'($urandom);
      rsp_ready   = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 5) == 0) status_in = $urandom & 32'hF;
      tick();
      check_all("rand");
    end

    settle();
    rsp_ready = 1'b0;
    drive(1'b1, 32'h22, 32'h12345678, 4'hF);
    tick();
    check_all("pre-reset");
    reset_n = 1'b0;
    #1;
    chk("midreset rsp_valid", 32'(rsp_valid), 32'h0);
    for (int i = 0; i < NC; i++)
      chk($sformatf("midreset ctrl%0d", i), control_out[32*i +: 32], 32'h0);
    model_reset();
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    reset_n = 1'b1;
    tick();
    check_all("post-reset");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mmio_register_bank.md
Name: mmio_register_bank

Overview:
- Parametrised successor to the fixed peripheral register map.
- N read/write control words and M read-only sampled status words sit in one word-addressed window starting at BASE_ADDR.
- Adds a valid/ready request/response handshake, byte strobes, and registered read data with error signalling.
- Adds sticky per-status-word change flags (write-1-to-clear).
- Sits between the CPU data bus decoder and the peripheral control/status buses.

Parameters:
- NUM_CONTROL, 6, number of 32-bit R/W control registers (1..64).
- NUM_STATUS, 1, number of 32-bit read-only status words (1..32).
- BASE_ADDR, 32'h20, word address of control register 0.
- CONTROL_RESET, 32'h0, reset value of every control register.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  bank can accept a request.
- req_write  in  1  1 = write, 0 = read.
- req_address  in  32  word address.
- req_wdata  in  32  write data.
- req_wstrb  in  4  byte enables; bit k covers [8k+7:8k].
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  32  read data (0 for writes and errors).
- rsp_error  out  1  address out of window, or write to a read-only word.
- status_in  in  32*NUM_STATUS  live peripheral status.
- control_out  out  32*NUM_CONTROL  control registers, word i at [32i+31:32i].
- irq  out  1  change interrupt (see Optional Feature).

Behaviour:
- Reset (async assert, sync release):
  - control words = CONTROL_RESET; status samples, change flags and irq enable = 0.
  - rsp_valid = 0, rsp_rdata = 0, rsp_error = 0, irq = 0, FSM = IDLE, prime = 1.
- Address map, relative offset o = req_address - BASE_ADDR:
  - 0..NUM_CONTROL-1: control words, R/W.
  - NUM_CONTROL..NUM_CONTROL+NUM_STATUS-1: status samples, RO.
  - C = NUM_CONTROL+NUM_STATUS: CHANGE flags, read / write-1-to-clear, bits [NUM_STATUS-1:0], upper bits read 0.
  - C+1: IRQ_ENABLE (feature only).
  - Anything else, including addresses below BASE_ADDR (unsigned wrap): error.
- FSM:
  - IDLE: rsp_valid = 0.
  - RESP: rsp_valid = 1; outputs held stable until rsp_ready.
  - req_ready = (state == IDLE) || rsp_ready.
  - Accept = req_valid && req_ready. On accept: state -> RESP and the response registers load.
  - RESP with rsp_ready and no new accept: state -> IDLE.
  - Back-to-back accepts are allowed, giving one response per cycle.
- Latency:
  - A request accepted at edge N has its response valid after edge N.
  - A write's effect is visible on control_out after the same edge N.
- Writes:
  - Only strobed bytes update.
  - wstrb = 0 is a legal no-op with rsp_error = 0.
  - Writes to status words: no effect, rsp_error = 1.
  - CHANGE write: each 1 bit clears its flag; only byte lanes enabled by wstrb apply.
- Reads:
  - Return the current register value at accept time.
  - A status read returns the registered sample, never live status_in.
- Status sampling and change detection:
  - Every cycle, sample <= status_in.
  - flag[i] is set when status_in word i != sample word i, except in the first cycle after reset release (prime), which only loads samples.
  - If a set and a W1C clear hit the same flag in the same cycle, the set wins.
- Reset asserted mid-transaction: the pending response is discarded; the requester must reissue.

Optional Feature:
- Macro: MMIO_CHANGE_IRQ_EN.
- Defined:
  - Adds the IRQ_ENABLE register at offset C+1, R/W, bits [NUM_STATUS-1:0].
  - irq is registered: irq <= |(flags & enable), one cycle after the flag or enable changes.
- Undefined:
  - Offset C+1 returns an error.
  - irq is tied 0.

Decomposition:
- Add to the peripherals package:
  - mmio_req_t and mmio_rsp_t structs.
  - mmio_state_t enum {IDLE, RESP}.
  - Offset helper constants (control, status, change, irq-enable offsets as functions of the parameters).
- Sub-module mmio_change_detector: sampling, prime, and sticky W1C flags, parametrised by NUM_STATUS.

Test Plan:
- Defaults, write 0x20 data 0xDEADBEEF wstrb 4'hF -> control_out[31:0] = 0xDEADBEEF one edge after accept; read 0x20 -> rsp_rdata 0xDEADBEEF, rsp_error 0.
- Write 0x21 data 0xAABBCCDD wstrb 4'b0101 over 0 -> read 0x21 returns 0x00BB00DD.
- status_in 0 -> 0x5 after the prime cycle -> read 0x26 = 0x5, read 0x27 = 0x1; write 0x27 data 0x1 -> read 0x27 = 0x0. Same-cycle change and clear -> flag stays 1.
- Write 0x26 -> rsp_error 1, sample unchanged. Read 0x29 and read 0x1F -> rsp_error 1, rdata 0.
- Hold rsp_ready = 0 for 3 cycles -> req_ready 0, response stable. Then rsp_ready = 1 with req_valid = 1 -> accept the same cycle, next response after the next edge.
- MMIO_CHANGE_IRQ_EN: write 0x28 = 0x1, toggle status bit -> irq = 1 one cycle after the flag sets; W1C -> irq = 0. Assert reset_n = 0 while in RESP -> rsp_valid = 0 and control_out = 0 immediately.
